seq_mult_ctrl: RTL and testbench

Parametrised control sequencer for an iterative N-bit shift-add multiplier datapath. Accepts a start request, issues a one-cycle operand load, then drives N arithmetic/shift iterations from the multiplier LSB bits fed back by the datapath. It then raises a sticky done flag. Replaces the fixed 6-iteration counter with a width-generic FSM that has a busy/done handshake, abort and optional Booth recoding.

---
 rtl/seq_mult_pkg.sv | 22 ++
 rtl/seq_mult_ctrl_iter_cnt.sv | 31 +++
 rtl/seq_mult_ctrl.sv | 131 +++++++++++++
 tb/tb_seq_mult_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types for the iterative multiplier sequencer: FSM states, {add,sub} op code,
// and the iteration-counter width helper.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic add;
    logic sub;
  } op_t;

  // Counter must hold the value N itself (held while DONE), hence N+1 codes.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_mult_ctrl_iter_cnt.sv
// Iteration counter: synchronous clear beats enable; flags the last iteration (count == N-1).
module mult_iter_cnt
  import seq_mult_pkg::*;
#(
  parameter int unsigned N     = 6,
  parameter int unsigned CNT_W = cnt_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;
  assign term  = (r_count == CNT_W'(N - 1));

endmodule

// File: rtl/seq_mult_ctrl.sv
// Control sequencer for an N-bit iterative shift-add multiplier datapath.
// Define SEQ_MULT_BOOTH_EN for radix-2 Booth (signed) decode; default is unsigned shift-add.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int unsigned N = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    q0,
  input  logic                    qm1,
  output logic                    load,
  output logic                    add,
  output logic                    sub,
  output logic                    shift,
  output logic                    busy,
  output logic                    done,
  output logic [cnt_width(N)-1:0] iter
);

  localparam int unsigned CNT_W = cnt_width(N);

  state_e           r_state;
  logic             r_load;
  logic             r_shift;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic             w_clr;
  logic             w_en;
  logic             w_term;
  logic [CNT_W-1:0] w_count;
  op_t              w_op;

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_clr    = abort || w_accept;
  assign w_en     = (r_state == ST_RUN);

  mult_iter_cnt #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .en    (w_en),
    .count (w_count),
    .term  (w_term)
  );

  // Sequencer; Moore outputs are registered alongside the state they decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_load  <= 1'b0;
      r_shift <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (abort) begin
      r_state <= ST_IDLE;
      r_load  <= 1'b0;
      r_shift <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_load  <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_state <= ST_RUN;
          r_load  <= 1'b0;
          r_shift <= 1'b1;
        end
        ST_RUN: begin
          if (w_term) begin
            r_state <= ST_DONE;
            r_shift <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_load  <= 1'b0;
          r_shift <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SEQ_MULT_BOOTH_EN
  logic w_unused_qm1;
  assign w_unused_qm1 = qm1;
`endif

  // Mealy add/sub decode, applied in the same cycle as the shift.
  always_comb begin
    w_op.add = 1'b0;
    w_op.sub = 1'b0;
    if (r_state == ST_RUN) begin
`ifdef SEQ_MULT_BOOTH_EN
      case ({q0, qm1})
        2'b10:   w_op.sub = 1'b1;
        2'b01:   w_op.add = 1'b1;
        default: w_op.add = 1'b0;
      endcase
`else
      w_op.add = q0;
`endif
    end
  end

  assign load  = r_load;
  assign shift = r_shift;
  assign busy  = r_busy;
  assign done  = r_done;
  assign add   = w_op.add;
  assign sub   = w_op.sub;
  assign iter  = w_count;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl: N=6 and N=16 instances share stimulus and are checked each cycle
// against a phase-counting model, plus directed literal checks on latency and decode.
module tb_seq_mult_ctrl;

  localparam int unsigned NA = 6;
  localparam int unsigned NB = 16;
  localparam int unsigned WA = $clog2(NA + 1);
  localparam int unsigned WB = $clog2(NB + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic q0 = 1'b0;
  logic qm1 = 1'b0;

  logic a_load, a_add, a_sub, a_shift, a_busy, a_done;
  logic [WA-1:0] a_iter;
  logic b_load, b_add, b_sub, b_shift, b_busy, b_done;
  logic [WB-1:0] b_iter;

  int vectors = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int e0 = 0;
  bit chk_en = 1'b0;

  bit          m_act [2];
  int unsigned m_k   [2];
  bit          m_done[2];

  seq_mult_ctrl #(.N(NA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .q0(q0), .qm1(qm1),
    .load(a_load), .add(a_add), .sub(a_sub), .shift(a_shift), .busy(a_busy),
    .done(a_done), .iter(a_iter)
  );

  seq_mult_ctrl #(.N(NB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .q0(q0), .qm1(qm1),
    .load(b_load), .add(b_add), .sub(b_sub), .shift(b_shift), .busy(b_busy),
    .done(b_done), .iter(b_iter)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned nval(input int i);
    return (i == 0) ? NA : NB;
  endfunction

  // Model: k = cycles since the operation began (0 = load cycle, 1..N = iterations).
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n || abort) begin
        m_act[i]  = 1'b0;
        m_k[i]    = 0;
        m_done[i] = 1'b0;
      end else if (m_act[i]) begin
        if (m_k[i] == nval(i)) begin
          m_act[i]  = 1'b0;
          m_done[i] = 1'b1;
        end else begin
          m_k[i] = m_k[i] + 1;
        end
      end else if (start) begin
        m_act[i]  = 1'b1;
        m_k[i]    = 0;
        m_done[i] = 1'b0;
      end
    end
  end

  function automatic logic [10:0] exp_vec(input int i);
    logic       ld, rn, ad, sb;
    logic [4:0] it;
    ld = m_act[i] && (m_k[i] == 0);
    rn = m_act[i] && (m_k[i] >= 1);
`ifdef SEQ_MULT_BOOTH_EN
    ad = rn && !q0 && qm1;
    sb = rn && q0 && !qm1;
`else
    ad = rn && q0;
    sb = 1'b0;
`endif
    if (m_act[i]) it = (m_k[i] == 0) ? 5'd0 : 5'(m_k[i] - 1);
    else          it = m_done[i] ? 5'(nval(i)) : 5'd0;
    return {ld, ad, sb, rn, m_act[i], m_done[i], it};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle_n6",  32'({a_load, a_add, a_sub, a_shift, a_busy, a_done, 5'(a_iter)}), 32'(exp_vec(0)));
      check("cycle_n16", 32'({b_load, b_add, b_sub, b_shift, b_busy, b_done, 5'(b_iter)}), 32'(exp_vec(1)));
    end
  end

  task automatic op_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    e0 = cyc_cnt;
  endtask

  task automatic wait_done(input int sel, output int lat);
    int g;
    g = 0;
    while ((((sel == 0) ? a_done : b_done) !== 1'b1) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    lat = cyc_cnt - e0;
  endtask

  task automatic wait_iter_a(input int unsigned it);
    int g;
    g = 0;
    @(negedge clk);
    while (!(a_shift === 1'b1 && a_iter == WA'(it)) && g < 50) begin
      @(negedge clk);
      g++;
    end
  endtask

  initial begin
    bit [5:0] pat;
    bit [5:0] addh, subh;
    logic     prev;
    int       busy_n, lat;

    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({a_load, a_add, a_sub, a_shift, a_busy, a_done, a_iter}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Nominal operation with a directed multiplier bit stream.
    pat = 6'b001101;
    prev = 1'b0;
    addh = '0;
    subh = '0;
    op_start();
    @(negedge clk);
    check("nom_load", 32'(a_load), 32'd1);
    busy_n = int'(a_busy);
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      q0 = pat[j];
      qm1 = prev;
      prev = pat[j];
      @(negedge clk);
      addh[j] = a_add;
      subh[j] = a_sub;
      busy_n += int'(a_busy);
    end
    @(posedge clk); #1;
    check("nom_done", 32'(a_done), 32'd1);
    check("nom_iter", 32'(a_iter), 32'd6);
    check("nom_busy_cycles", 32'(busy_n), 32'd7);
    check("nom_latency", 32'(cyc_cnt - e0), 32'd7);
`ifdef SEQ_MULT_BOOTH_EN
    check("decode_add", 32'(addh), 32'b010010);
    check("decode_sub", 32'(subh), 32'b000101);
`else
    check("decode_add", 32'(addh), 32'b001101);
    check("decode_sub", 32'(subh), 32'd0);
`endif
    q0 = 1'b0;
    qm1 = 1'b0;

    // Sticky done, then restart from DONE.
    repeat (5) begin
      @(negedge clk);
      check("sticky_done", 32'(a_done), 32'd1);
    end
    op_start();
    check("restart_done_drop", 32'(a_done), 32'd0);
    wait_done(0, lat);
    check("restart_latency", 32'(lat), 32'd7);

    // Abort everything, then a full N=16 run.
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_idle", 32'({a_busy, a_done, b_busy, b_done}), 32'd0);
    op_start();
    wait_done(1, lat);
    check("n16_latency", 32'(lat), 32'd17);
    check("n16_iter", 32'(b_iter), 32'd16);

    // Abort together with start during RUN.
    op_start();
    wait_iter_a(2);
    #1 abort = 1'b1; start = 1'b1;
    @(posedge clk); #1 abort = 1'b0; start = 1'b0;
    check("abort_run_state", 32'({a_load, a_shift, a_busy, a_done}), 32'd0);
    check("abort_run_iter", 32'(a_iter), 32'd0);
    op_start();
    wait_done(0, lat);
    check("post_abort_latency", 32'(lat), 32'd7);

    // Start during RUN must not restart the sequence.
    op_start();
    wait_iter_a(3);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(0, lat);
    check("ignored_start_latency", 32'(lat), 32'd7);

    // Asynchronous reset mid-RUN.
    op_start();
    wait_iter_a(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_a", 32'({a_load, a_add, a_sub, a_shift, a_busy, a_done, a_iter}), 32'd0);
    check("async_rst_b", 32'({b_load, b_add, b_sub, b_shift, b_busy, b_done, b_iter}), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("post_rst_idle", 32'({a_busy, a_done, b_busy, b_done}), 32'd0);

    // Randomized traffic.
    repeat (800) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 24) == 0);
      q0    = 1'($urandom);
      qm1   = 1'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
